// File: rtl/mac_pkg.sv
// mac_pkg: shared state type, default widths and chunk-count helper for the MAC resolve path
package mac_pkg;
  typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_t;
  localparam int MAC_W = 32;
  localparam int MAC_CHUNK = 8;
  function automatic int chunk_count(int n, int c);
    return n / c;
  endfunction
endpackage

// File: rtl/csa_accum_resolve_if.sv
// csa_accum_resolve_if: beat input and resolved-result output channels of the accumulator
interface csa_accum_resolve_if #(parameter int N = mac_pkg::MAC_W);
  logic in_valid;
  logic in_ready;
  logic in_first;
  logic in_last;
  logic [N-1:0] in_ps;
  logic [N-1:0] in_pc;
  logic out_valid;
  logic out_ready;
  logic [N-1:0] out_sum;
  modport slave(input in_valid, in_first, in_last, in_ps, in_pc, out_ready, output in_ready, out_valid, out_sum);
  modport master(output in_valid, in_first, in_last, in_ps, in_pc, out_ready, input in_ready, out_valid, out_sum);
endinterface

// File: rtl/cpa_chunk.sv
// cpa_chunk: W-bit ripple adder slice with carry-in/out used by the chunked resolve
module cpa_chunk #(parameter int W = 8) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  assign {co, s} = a + b + ci;
endmodule

// File: rtl/csa.sv
// csa: N-bit 3:2 carry-save adder; carry output is unshifted (bit i has weight 2^(i+1))
module csa #(parameter int N = 32) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] s,
  output logic [N-1:0] co
);
  assign s = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/csa_accum_resolve.sv
// csa_accum_resolve: carry-save accumulation of (ps, pc) beats, chunked carry-propagate resolve at group end
module csa_accum_resolve import mac_pkg::*; #(
  parameter int N = MAC_W,
  parameter int CHUNK = MAC_CHUNK
) (
  input logic clk,
  input logic rst_n,
  csa_accum_resolve_if.slave bus
);
  localparam int NC = chunk_count(N, CHUNK);
  localparam int KW = NC > 1 ? $clog2(NC) : 1;
  state_t state;
  logic [N-1:0] acc_s, acc_c, base_s, base_c, y, s1, c1, s2, c2;
  logic [KW-1:0] k;
  logic carry, cco;
  logic [CHUNK-1:0] ca, cb, cs;
  assign base_s = bus.in_first ? '0 : acc_s;
  assign base_c = bus.in_first ? '0 : acc_c;
  assign y = bus.in_pc << 1;
  csa #(.N(N)) u_l1 (.a(base_s), .b(base_c), .c(bus.in_ps), .s(s1), .co(c1));
  csa #(.N(N)) u_l2 (.a(s1), .b(c1 << 1), .c(y), .s(s2), .co(c2));
  assign ca = acc_s[k*CHUNK +: CHUNK];
  assign cb = acc_c[k*CHUNK +: CHUNK];
  cpa_chunk #(.W(CHUNK)) u_cpa (.a(ca), .b(cb), .ci(carry), .s(cs), .co(cco));
  assign bus.in_ready = state == ACCUM;
  // FSM: accumulate beats, resolve one chunk per cycle, hold result until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc_s <= '0;
      acc_c <= '0;
      k <= '0;
      carry <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sum <= '0;
    end else begin
      case (state)
        ACCUM: if (bus.in_valid) begin
          acc_s <= s2;
          acc_c <= c2 << 1;
          if (bus.in_last) begin
            state <= RESOLVE;
            k <= '0;
            carry <= 1'b0;
          end
        end
        RESOLVE: begin
          bus.out_sum[k*CHUNK +: CHUNK] <= cs;
          carry <= cco;
          k <= k + 1'b1;
          if (k == KW'(NC - 1)) begin
            state <= DONE;
            bus.out_valid <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          acc_s <= '0;
          acc_c <= '0;
          state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_accum_resolve.sv
// tb_csa_accum_resolve: directed beats with scoreboarded expected sums and latency/backpressure/reset checks
module tb_csa_accum_resolve;
  import mac_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  csa_accum_resolve_if #(.N(32)) bus();
  csa_accum_resolve #(.N(32), .CHUNK(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // monitor: compare each completed output handshake against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected result: got %h expected none", bus.out_sum);
      end else chk("result", bus.out_sum, exp_q.pop_front());
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] ps, input logic [31:0] pc, input logic first, input logic last);
    bus.in_ps = ps;
    bus.in_pc = pc;
    bus.in_first = first;
    bus.in_last = last;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !bus.in_ready; i++) tick();
    if (!bus.in_ready) chk("send timeout in_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic check_latency;
    int e = 0;
    while (!bus.out_valid && e < 20) begin
      tick();
      e++;
    end
    chk("latency", e, 32'd4);
  endtask
  task automatic wait_idle;
    int e = 0;
    while (!bus.in_ready && e < 50) begin
      tick();
      e++;
    end
    chk("return to accum", {31'b0, bus.in_ready}, 32'd1);
  endtask
  task automatic run1(input logic [31:0] ps, input logic [31:0] pc, input logic first, input logic [31:0] exp);
    send(ps, pc, first, 1'b1);
    exp_q.push_back(exp);
    check_latency();
    wait_idle();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last = 1'b0;
    bus.in_ps = '0;
    bus.in_pc = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("reset out_sum", bus.out_sum, 32'd0);
    chk("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
    run1(32'h000000FF, 32'h00000001, 1'b1, 32'h00000101);
    send(32'd5, 32'd0, 1'b1, 1'b0);
    send(32'd3, 32'd1, 1'b0, 1'b0);
    send(32'h10, 32'h8, 1'b0, 1'b1);
    exp_q.push_back(32'h0000002A);
    check_latency();
    wait_idle();
    send(32'h000000FF, 32'd0, 1'b1, 1'b0);
    send(32'd1, 32'd0, 1'b0, 1'b1);
    exp_q.push_back(32'h00000100);
    check_latency();
    wait_idle();
    send(32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);
    send(32'd2, 32'd0, 1'b0, 1'b1);
    exp_q.push_back(32'h00000001);
    check_latency();
    wait_idle();
    run1(32'd0, 32'h80000000, 1'b1, 32'h00000000);
    bus.out_ready = 1'b0;
    send(32'h00001234, 32'd0, 1'b1, 1'b1);
    exp_q.push_back(32'h00001234);
    check_latency();
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in_ps = 32'hDEAD0000 + i;
      bus.in_first = 1'b0;
      bus.in_last = 1'b1;
      tick();
      chk("bp out_sum stable", bus.out_sum, 32'h00001234);
      chk("bp in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("bp out_valid", {31'b0, bus.out_valid}, 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();
    run1(32'd7, 32'd0, 1'b0, 32'h00000007);
    send(32'h55, 32'd0, 1'b1, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid-resolve reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mid-resolve reset out_sum", bus.out_sum, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post-reset in_ready", {31'b0, bus.in_ready}, 32'd1);
    run1(32'd9, 32'd0, 1'b0, 32'h00000009);
    repeat (3) tick();
    chk("scoreboard drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/csa_accum_resolve.md
Name: csa_accum_resolve

Overview:
- Downstream consumer of the MAC carry-save adder stage.
- Accepts a stream of (partial-sum, partial-carry) vector pairs and accumulates them in redundant carry-save form, one beat per cycle.
- On the last beat of a group, resolves the redundant pair into a binary result with a chunked multi-cycle carry-propagate adder.
- Presents the result on a valid/ready output; the result is the MAC accumulator value handed to the PE writeback.

Parameters:
- N, 32, datapath width; all arithmetic is modulo 2^N.
- CHUNK, 8, bits resolved per cycle by the carry-propagate adder; N must be a multiple of CHUNK.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- in_first  input  1  beat starts a new group; the accumulator is treated as zero
- in_last  input  1  beat ends the group and triggers resolve
- in_ps  input  N  partial sum; bit i has weight 2^i
- in_pc  input  N  partial carry, unshifted; bit i has weight 2^(i+1)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_sum  output  N  resolved sum mod 2^N

Behaviour:
- Reset (async, rst_n=0):
  - state=ACCUM; acc_s=0, acc_c=0; chunk index=0; carry register=0.
  - out_valid=0, out_sum=0; in_ready=1 once rst_n deasserts.
- States: ACCUM, RESOLVE, DONE.
- ACCUM:
  - in_ready=1. A beat is accepted when in_valid && in_ready.
  - On acceptance:
    - x = in_ps; y = in_pc shifted left by 1, with in_pc[N-1] discarded.
    - Base (a, b) = (0, 0) if in_first, else (acc_s, acc_c).
    - 4:2 compress a, b, x, y with two 3:2 levels: level 1 (a, b, x) -> (s1, c1); level 2 (s1, c1<<1, y) -> (s2, c2).
    - Register acc_s=s2 and acc_c=c2<<1. Bits shifted out of the MSB are dropped.
  - If the accepted beat has in_last=1: go to RESOLVE; chunk index=0; carry register=0.
  - No accepted beat: state and accumulator unchanged.
- RESOLVE:
  - in_ready=0.
  - Each cycle, for chunk k: out_sum[k*CHUNK +: CHUNK] = acc_s chunk + acc_c chunk + carry; carry register = chunk carry-out; k increments.
  - After N/CHUNK cycles, go to DONE and set out_valid=1. The final carry-out is discarded.
- Latency: out_valid rises N/CHUNK clock edges after the edge that accepted the in_last beat (4 for the defaults).
- DONE:
  - out_valid=1; in_ready=0; out_sum held stable while waiting for out_ready.
  - On out_valid && out_ready: out_valid=0, acc_s=acc_c=0, state=ACCUM.
  - in_ready rises the cycle after the output handshake; there is no same-cycle pass-through.
- Boundary cases:
  - in_first && in_last on the same beat: single-beat group, result = in_ps + 2*in_pc mod 2^N.
  - in_first=0 on the first beat after reset or after a handshake: the accumulator is already zero, so the result is identical to in_first=1.
  - in_valid while in_ready=0: ignored, with no side effects.
  - out_ready while out_valid=0: ignored.
  - Overflow beyond 2^N: silently wraps.
  - rst_n asserted in any state, including mid-RESOLVE or DONE: immediate return to reset values; the partial result is lost.

Decomposition:
- Shared package mac_pkg holds:
  - state enum {ACCUM, RESOLVE, DONE};
  - default width constant MAC_W=32;
  - default chunk constant MAC_CHUNK=8;
  - chunk-count function N/CHUNK.
- The 4:2 compressor is built from two instances of the team's existing N-bit CSA block.
- One natural new sub-module: cpa_chunk, a CHUNK-bit adder with carry-in/carry-out used by the resolve stage.
- The FSM and accumulator registers stay in the top module.

Test Plan (N=32, CHUNK=8):
- Reset: hold rst_n=0 for 3 cycles, then release -> out_valid=0, out_sum=0, in_ready=1 on the first cycle after release.
- Single beat with first=last=1, ps=0x000000FF, pc=0x00000001 -> out_sum=0x00000101; out_valid rises exactly 4 edges after the accept edge.
- Three beats (ps,pc) = (5,0), (3,1), (0x10,0x8) with last on the third -> out_sum=0x0000002A.
- Cross-chunk carry and wrap:
  - (0x000000FF,0) then (1,0) last -> out_sum=0x00000100.
  - (0xFFFFFFFF,0) then (2,0) last -> out_sum=0x00000001.
  - pc=0x80000000 alone -> out_sum=0x00000000.
- Backpressure: out_ready=0 for 10 cycles while in_valid pulses -> out_sum stable, in_ready=0, no beats absorbed. After the handshake, the new group (7,0) last -> out_sum=0x00000007.
- Reset mid-RESOLVE: assert rst_n=0 in the 2nd resolve cycle -> out_valid=0 immediately, in_ready=1 after release. The next group (9,0) last -> out_sum=0x00000009.
